// File: rtl/regbank_pkg.sv
// Shared types and default sizes for the clearable register bank.
package regbank_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

endpackage

// File: rtl/regbank_clr_if.sv
// Register bank access bus: clear request/busy, two read ports, one write port.
interface regbank_clr_if
  import regbank_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic              clr_req;
  logic              busy;
  logic [ADDR_W-1:0] RegLe1;
  logic [ADDR_W-1:0] RegLe2;
  logic [ADDR_W-1:0] RegEscr;
  logic              EscrReg;
  logic [DATA_W-1:0] datain;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;

  modport master (
    output clr_req, RegLe1, RegLe2, RegEscr, EscrReg, datain,
    input  busy, data1, data2
  );

  modport slave (
    input  clr_req, RegLe1, RegLe2, RegEscr, EscrReg, datain,
    output busy, data1, data2
  );

endinterface

// File: rtl/regbank_clr_seq.sv
// Clear sequencer: walks clr_ptr over every entry after reset or on clr_req,
// then parks in ST_IDLE. Produces the clear write strobe/address for the array.
module regbank_clr_seq
  import regbank_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NREGS  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              busy,
  output logic              idle,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NREGS - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] clr_ptr_reg, clr_ptr_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_CLEAR;
      clr_ptr_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_ptr_reg <= clr_ptr_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_ptr_next = clr_ptr_reg;
    clr_we       = 1'b0;
    case (state_reg)
      ST_CLEAR: begin
        clr_we = 1'b1;
        // Pointer holds at the last entry instead of wrapping.
        if (clr_ptr_reg == LAST_PTR) begin
          state_next = ST_IDLE;
        end else begin
          clr_ptr_next = clr_ptr_reg + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        if (clr_req) begin
          state_next   = ST_CLEAR;
          clr_ptr_next = '0;
        end
      end
      default: begin
        state_next   = ST_CLEAR;
        clr_ptr_next = '0;
      end
    endcase
  end

  assign busy     = (state_reg == ST_CLEAR);
  assign idle     = (state_reg == ST_IDLE);
  assign clr_addr = clr_ptr_reg;

endmodule

// File: rtl/regbank_clr.sv
// 2R/1W register bank with registered reads, optional hardwired r0 and a clear
// sequencer. Define REGBANK_BYPASS_EN to forward an accepted write to a same-address read.
module regbank_clr
  import regbank_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NREGS    = 1 << ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  regbank_clr_if.slave  bus
);

  logic              busy;
  logic              idle;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  regbank_clr_seq #(
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (bus.clr_req),
    .busy     (busy),
    .idle     (idle),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  logic [DATA_W-1:0] mem [NREGS];

  logic              wr_in_range;
  logic              wr_zero;
  logic              wr_accept;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign wr_in_range = (32'(bus.RegEscr) < NREGS);
  assign wr_zero     = (ZERO_REG != 0) && (bus.RegEscr == '0);
  // A clear request in the same cycle drops the write.
  assign wr_accept   = idle && !bus.clr_req && bus.EscrReg && wr_in_range && !wr_zero;

  assign mem_we    = clr_we | wr_accept;
  assign mem_waddr = clr_we ? clr_addr : bus.RegEscr;
  assign mem_wdata = clr_we ? '0 : bus.datain;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];

  assign rd_addr[0] = bus.RegLe1;
  assign rd_addr[1] = bus.RegLe2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic              rd_valid;
      logic [DATA_W-1:0] rd_data_next;
      logic [DATA_W-1:0] rd_data_reg;

      assign rd_valid = (32'(rd_addr[gi]) < NREGS) &&
                        !((ZERO_REG != 0) && (rd_addr[gi] == '0));

      // Array is read before the same-edge write lands; clearing forces zeros.
      always_comb begin
        rd_data_next = '0;
        if (idle) begin
          if (rd_valid) begin
            rd_data_next = mem[rd_addr[gi]];
          end
`ifdef REGBANK_BYPASS_EN
          if (wr_accept && (bus.RegEscr == rd_addr[gi])) begin
            rd_data_next = bus.datain;
          end
`endif
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data_reg <= '0;
        end else begin
          rd_data_reg <= rd_data_next;
        end
      end

      assign rd_data[gi] = rd_data_reg;
    end
  endgenerate

  assign bus.busy  = busy;
  assign bus.data1 = rd_data[0];
  assign bus.data2 = rd_data[1];

endmodule

// File: tb/tb_regbank_clr.sv
// Bench for regbank_clr: two instances (32 regs with hardwired r0, 20 regs without)
// driven in lockstep and compared against a behavioural array model.
module tb_regbank_clr;

`ifdef REGBANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        clr_v = 1'b0;
  logic        we_v  = 1'b0;
  logic [4:0]  wa_v  = '0;
  logic [31:0] din_v = '0;
  logic [4:0]  l1_v  = '0;
  logic [4:0]  l2_v  = '0;

  regbank_clr_if #(.DATA_W(32), .ADDR_W(5)) ifa ();
  regbank_clr_if #(.DATA_W(32), .ADDR_W(5)) ifb ();

  assign ifa.clr_req = clr_v;  assign ifb.clr_req = clr_v;
  assign ifa.EscrReg = we_v;   assign ifb.EscrReg = we_v;
  assign ifa.RegEscr = wa_v;   assign ifb.RegEscr = wa_v;
  assign ifa.datain  = din_v;  assign ifb.datain  = din_v;
  assign ifa.RegLe1  = l1_v;   assign ifb.RegLe1  = l1_v;
  assign ifa.RegLe2  = l2_v;   assign ifb.RegLe2  = l2_v;

  regbank_clr #(.DATA_W(32), .ADDR_W(5), .NREGS(32), .ZERO_REG(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  regbank_clr #(.DATA_W(32), .ADDR_W(5), .NREGS(20), .ZERO_REG(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  logic [31:0] act_d1 [2];
  logic [31:0] act_d2 [2];
  logic        act_b  [2];
  assign act_d1[0] = ifa.data1;  assign act_d1[1] = ifb.data1;
  assign act_d2[0] = ifa.data2;  assign act_d2[1] = ifb.data2;
  assign act_b[0]  = ifa.busy;   assign act_b[1]  = ifb.busy;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: plain array per instance plus a count of clear edges left.
  logic [31:0] mem_m [2][32];
  int          busy_cnt [2];
  int          n_m [2] = '{32, 20};
  bit          z_m [2] = '{1'b1, 1'b0};

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      busy_cnt[i] = n_m[i];
      for (int j = 0; j < 32; j++) mem_m[i][j] = '0;
    end
  endfunction

  function automatic logic [31:0] model_rd(input int i, input logic [4:0] a);
    if (int'(a) >= n_m[i] || (z_m[i] && a == 5'd0)) return 32'h0;
    return mem_m[i][a];
  endfunction

  task automatic drive(input bit c, input bit w, input logic [4:0] a, input logic [31:0] d,
                       input logic [4:0] r1, input logic [4:0] r2);
    clr_v = c; we_v = w; wa_v = a; din_v = d; l1_v = r1; l2_v = r2;
  endtask

  // One clock edge: predict from the model, advance it, then compare both instances.
  task automatic step(input string tag);
    logic [31:0] e1 [2];
    logic [31:0] e2 [2];
    logic        eb [2];
    for (int i = 0; i < 2; i++) begin
      if (busy_cnt[i] > 0) begin
        e1[i] = '0;
        e2[i] = '0;
        busy_cnt[i]--;
      end else begin
        bit acc;
        acc = we_v && !clr_v && (int'(wa_v) < n_m[i]) && !(z_m[i] && wa_v == 5'd0);
        e1[i] = model_rd(i, l1_v);
        e2[i] = model_rd(i, l2_v);
        if (BYP && acc && wa_v == l1_v) e1[i] = din_v;
        if (BYP && acc && wa_v == l2_v) e2[i] = din_v;
        if (clr_v) begin
          busy_cnt[i] = n_m[i];
          for (int j = 0; j < 32; j++) mem_m[i][j] = '0;
        end else if (acc) begin
          mem_m[i][wa_v] = din_v;
        end
      end
      eb[i] = (busy_cnt[i] > 0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_data1_%0d", tag, i), act_d1[i], e1[i]);
      check($sformatf("%s_data2_%0d", tag, i), act_d2[i], e2[i]);
      check($sformatf("%s_busy_%0d", tag, i), 32'(act_b[i]), 32'(eb[i]));
    end
  endtask

  // Counts edges until busy drops on each instance, bounded.
  task automatic count_clear(input string tag, input int exp_a, input int exp_b);
    int ca;
    int cb;
    ca = 0;
    cb = 0;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int k = 1; k <= 100; k++) begin
      step(tag);
      if (cb == 0 && !act_b[1]) cb = k;
      if (!act_b[0]) begin
        ca = k;
        break;
      end
    end
    check($sformatf("%s_edges_a", tag), 32'(ca), 32'(exp_a));
    check($sformatf("%s_edges_b", tag), 32'(cb), 32'(exp_b));
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a));
      step(tag);
    end
  endtask

  typedef struct {
    logic        clr;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] din;
    logic [4:0]  l1;
    logic [4:0]  l2;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        xb;
  } vec_t;

  vec_t tbl [8];

  initial begin
    // Expected values for the 32-entry, hardwired-r0 instance.
    tbl[0] = '{1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 5'd0,  32'h00001234, 5'd0,  5'd5,  32'h0, 32'hDEADBEEF, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0, 32'h0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd31, BYP ? 32'hA5A5A5A5 : 32'h0,
               BYP ? 32'hA5A5A5A5 : 32'h0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 5'd5,  32'h11111111, 5'd31, 5'd5,  32'hA5A5A5A5,
               BYP ? 32'h11111111 : 32'hDEADBEEF, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 5'd7,  32'h00000077, 5'd5,  5'd31, 32'h11111111, 32'hA5A5A5A5, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 5'd7,  32'h00000077, 5'd5,  5'd31, 32'h0, 32'h0, 1'b1};

    // Power-up reset
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy_a", 32'(ifa.busy), 32'h1);
    check("rst_busy_b", 32'(ifb.busy), 32'h1);
    check("rst_data1_a", ifa.data1, 32'h0);
    check("rst_data2_a", ifa.data2, 32'h0);
    rst_n = 1'b1;
    count_clear("init", 32, 20);
    read_all("init_rd");

    // Table-driven directed vectors
    for (int r = 0; r < 8; r++) begin
      drive(tbl[r].clr, tbl[r].we, tbl[r].wa, tbl[r].din, tbl[r].l1, tbl[r].l2);
      step("tbl");
      check($sformatf("tbl%0d_data1", r), ifa.data1, tbl[r].x1);
      check($sformatf("tbl%0d_data2", r), ifa.data2, tbl[r].x2);
      check($sformatf("tbl%0d_busy", r), 32'(ifa.busy), 32'(tbl[r].xb));
    end
    count_clear("tblclr", 31, 19);

    // r0 is writable only without the hardwired zero
    drive(1'b0, 1'b1, 5'd0, 32'h00001234, 5'd1, 5'd1);
    step("zr_wr");
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    step("zr_rd");
    check("zr0_a", ifa.data1, 32'h0);
    check("zr0_b", ifb.data1, 32'h00001234);

    // Address 25 is beyond the 20-entry instance
    drive(1'b0, 1'b1, 5'd25, 32'h0000CAFE, 5'd25, 5'd25);
    step("oor_wr");
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd25, 5'd25);
    step("oor_rd");
    check("oor_a", ifa.data1, 32'h0000CAFE);
    check("oor_b", ifb.data2, 32'h0);

    // Fill, then clear on request with a write attempted while busy
    for (int a = 1; a < 32; a++) begin
      drive(1'b0, 1'b1, 5'(a), 32'(a), 5'(a), 5'(a - 1));
      step("fill");
    end
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd17);
    step("clr");
    check("clr_busy_next_a", 32'(ifa.busy), 32'h1);
    drive(1'b0, 1'b1, 5'd3, 32'h0000FFFF, 5'd3, 5'd3);
    step("clr_wr");
    count_clear("fillclr", 31, 19);
    read_all("fillclr_rd");

    // Reset in the middle of read traffic
    drive(1'b0, 1'b1, 5'd9, 32'h00000099, 5'd0, 5'd0);
    step("pre_rst_wr");
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    step("pre_rst_rd");
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rstw_data1_a", ifa.data1, 32'h0);
    check("rstw_data2_b", ifb.data2, 32'h0);
    check("rstw_busy_a", 32'(ifa.busy), 32'h1);
    rst_n = 1'b1;
    count_clear("rstw", 32, 20);

    // Reset at clr_ptr == 10 restarts the whole clear
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    step("mid_clr");
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    repeat (10) step("mid_clr_run");
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rstc_busy_a", 32'(ifa.busy), 32'h1);
    check("rstc_busy_b", 32'(ifb.busy), 32'h1);
    check("rstc_data1_a", ifa.data1, 32'h0);
    check("rstc_data2_a", ifa.data2, 32'h0);
    rst_n = 1'b1;
    count_clear("rstc", 32, 20);

    // Random traffic against the model
    for (int k = 0; k < 1500; k++) begin
      logic [4:0] a;
      a = 5'($urandom);
      drive(($urandom_range(0, 63) == 0), 1'($urandom), a, $urandom,
            ($urandom_range(0, 3) == 0) ? a : 5'($urandom),
            ($urandom_range(0, 3) == 0) ? a : 5'($urandom));
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
